// File: rtl/regf_wb_sched_if.sv
// Issue, write-back and register-file write port bundle for the write-back scheduler.
// The master modport drives requests; the slave modport is the scheduler.
interface regf_wb_sched_if #(
  parameter int unsigned REG_NUM   = 16,
  parameter int unsigned CPU_WIDTH = 32,
  parameter int unsigned ADDR_W    = 5
);
  logic                 issue_valid;
  logic                 issue_ready;
  logic [ADDR_W-1:0]    issue_rd;
  logic                 issue_rd_en;
  logic [ADDR_W-1:0]    issue_rs1;
  logic                 issue_rs1_en;
  logic [ADDR_W-1:0]    issue_rs2;
  logic                 issue_rs2_en;

  logic                 exu_valid;
  logic                 exu_ready;
  logic [ADDR_W-1:0]    exu_rd;
  logic [CPU_WIDTH-1:0] exu_data;

  logic                 lsu_valid;
  logic                 lsu_ready;
  logic [ADDR_W-1:0]    lsu_rd;
  logic [CPU_WIDTH-1:0] lsu_data;

  logic                 rf_wen;
  logic [ADDR_W-1:0]    rf_waddr;
  logic [CPU_WIDTH-1:0] rf_wdata;
  logic [REG_NUM-1:0]   sb_busy;

  modport master (
    output issue_valid, issue_rd, issue_rd_en, issue_rs1, issue_rs1_en, issue_rs2, issue_rs2_en,
    input  issue_ready,
    output exu_valid, exu_rd, exu_data,
    input  exu_ready,
    output lsu_valid, lsu_rd, lsu_data,
    input  lsu_ready,
    input  rf_wen, rf_waddr, rf_wdata, sb_busy
  );

  modport slave (
    input  issue_valid, issue_rd, issue_rd_en, issue_rs1, issue_rs1_en, issue_rs2, issue_rs2_en,
    output issue_ready,
    input  exu_valid, exu_rd, exu_data,
    output exu_ready,
    input  lsu_valid, lsu_rd, lsu_data,
    output lsu_ready,
    output rf_wen, rf_waddr, rf_wdata, sb_busy
  );
endinterface

// File: rtl/regf_wb_sched.sv
// Write-back scheduler and scoreboard: round-robin EXU/LSU arbitration onto one registered
// regfile write port, with per-register pending bits gating instruction issue.
module regf_wb_sched #(
  parameter int unsigned REG_NUM   = 16,
  parameter int unsigned CPU_WIDTH = 32,
  parameter int unsigned ADDR_W    = 5
) (
  input  logic           clk,
  input  logic           rst,
  regf_wb_sched_if.slave bus
);

  typedef enum logic {RrExu, RrLsu} rr_e;

  rr_e                  rr_last_q, rr_last_d;
  logic [REG_NUM-1:0]   busy_q, busy_d;
  logic                 rf_wen_q, rf_wen_d;
  logic [ADDR_W-1:0]    rf_waddr_q, rf_waddr_d;
  logic [CPU_WIDTH-1:0] rf_wdata_q, rf_wdata_d;

  logic                 rs1_busy, rs2_busy, rd_busy, haz, issue_fire;
  logic                 exu_gnt, lsu_gnt, any_gnt, gnt_real;
  logic [ADDR_W-1:0]    gnt_rd;
  logic [CPU_WIDTH-1:0] gnt_data;

  // Null addresses (0 and >= REG_NUM) never match a loop index, so they never read busy.
  always_comb begin
    rs1_busy = 1'b0;
    rs2_busy = 1'b0;
    rd_busy  = 1'b0;
    for (int unsigned i = 1; i < REG_NUM; i++) begin
      if (bus.issue_rs1 == ADDR_W'(i)) rs1_busy = busy_q[i];
      if (bus.issue_rs2 == ADDR_W'(i)) rs2_busy = busy_q[i];
      if (bus.issue_rd  == ADDR_W'(i)) rd_busy  = busy_q[i];
    end
  end

  assign haz = (bus.issue_rs1_en & rs1_busy) | (bus.issue_rs2_en & rs2_busy) |
               (bus.issue_rd_en & rd_busy);
  assign bus.issue_ready = ~haz;
  assign issue_fire      = bus.issue_valid & ~haz;

  // On a tie, the requester not granted last time wins.
  assign exu_gnt  = bus.exu_valid & (~bus.lsu_valid | (rr_last_q == RrLsu));
  assign lsu_gnt  = bus.lsu_valid & ~exu_gnt;
  assign any_gnt  = exu_gnt | lsu_gnt;
  assign gnt_rd   = exu_gnt ? bus.exu_rd : bus.lsu_rd;
  assign gnt_data = exu_gnt ? bus.exu_data : bus.lsu_data;
  assign gnt_real = (gnt_rd != '0) && (32'(gnt_rd) < REG_NUM);

  assign bus.exu_ready = exu_gnt;
  assign bus.lsu_ready = lsu_gnt;

  always_comb begin
    rr_last_d  = rr_last_q;
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (any_gnt) begin
      rr_last_d  = exu_gnt ? RrExu : RrLsu;
      rf_wen_d   = gnt_real;
      rf_waddr_d = gnt_rd;
      rf_wdata_d = gnt_data;
    end
  end

  // Clear on the cycle the write is presented to the regfile; a same-cycle set wins.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned i = 1; i < REG_NUM; i++) begin
      if (rf_wen_q && (rf_waddr_q == ADDR_W'(i))) busy_d[i] = 1'b0;
      if (issue_fire && bus.issue_rd_en && (bus.issue_rd == ADDR_W'(i))) busy_d[i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_last_q  <= RrLsu;
      busy_q     <= '0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rr_last_q  <= rr_last_d;
      busy_q     <= busy_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign bus.rf_wen   = rf_wen_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;
  assign bus.sb_busy  = busy_q;

endmodule

// File: tb/tb_regf_wb_sched.sv
// Directed bench for regf_wb_sched: reset, RAW/WAW stalls, round-robin contention,
// null destinations and asynchronous reset, all against hand-computed expectations.
module tb_regf_wb_sched;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;

  regf_wb_sched_if #(.REG_NUM(16), .CPU_WIDTH(32), .ADDR_W(5)) bus ();

  regf_wb_sched #(.REG_NUM(16), .CPU_WIDTH(32), .ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle();
    bus.issue_valid  = 1'b0;
    bus.issue_rd     = '0;
    bus.issue_rd_en  = 1'b0;
    bus.issue_rs1    = '0;
    bus.issue_rs1_en = 1'b0;
    bus.issue_rs2    = '0;
    bus.issue_rs2_en = 1'b0;
    bus.exu_valid    = 1'b0;
    bus.exu_rd       = '0;
    bus.exu_data     = '0;
    bus.lsu_valid    = 1'b0;
    bus.lsu_rd       = '0;
    bus.lsu_data     = '0;
  endtask

  // Negedge plus a little, so registered outputs are settled and far from the rising edge.
  task automatic next_cyc();
    @(negedge clk);
    #1;
  endtask

  initial begin
    bit          exp_e[4];
    logic [4:0]  exp_a[4];
    logic [31:0] exp_d[4];
    n_vec = 0;
    n_bad = 0;
    exp_e = '{1'b1, 1'b0, 1'b1, 1'b0};
    exp_a = '{5'd1, 5'd2, 5'd1, 5'd2};
    exp_d = '{32'hA1, 32'hB2, 32'hA1, 32'hB2};

    // Reset held with a pending EXU request
    rst = 1'b0;
    idle();
    bus.exu_valid = 1'b1;
    bus.exu_rd    = 5'd5;
    bus.exu_data  = 32'h55;
    repeat (2) next_cyc();
    check("rst_wen", 32'(bus.rf_wen), 32'd0);
    check("rst_busy", 32'(bus.sb_busy), 32'd0);
    check("rst_waddr", 32'(bus.rf_waddr), 32'd0);
    check("rst_wdata", bus.rf_wdata, 32'd0);
    rst = 1'b1;
    #1;
    check("post_rst_exu_gnt", 32'(bus.exu_ready), 32'd1);
    next_cyc();
    check("post_rst_wen", 32'(bus.rf_wen), 32'd1);
    check("post_rst_waddr", 32'(bus.rf_waddr), 32'd5);
    check("post_rst_wdata", bus.rf_wdata, 32'h55);
    check("post_rst_busy", 32'(bus.sb_busy), 32'd0);
    bus.exu_valid = 1'b0;

    // RAW stall on x3
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd3;
    bus.issue_rd_en = 1'b1;
    #1;
    check("raw_first_ready", 32'(bus.issue_ready), 32'd1);
    next_cyc();
    check("raw_busy3", 32'(bus.sb_busy), 32'h8);
    bus.issue_rd_en  = 1'b0;
    bus.issue_rs1    = 5'd3;
    bus.issue_rs1_en = 1'b1;
    bus.exu_valid    = 1'b1;
    bus.exu_rd       = 5'd3;
    bus.exu_data     = 32'hDEADBEEF;
    #1;
    check("raw_stall_n", 32'(bus.issue_ready), 32'd0);
    check("raw_exu_gnt", 32'(bus.exu_ready), 32'd1);
    next_cyc();
    bus.exu_valid = 1'b0;
    #1;
    check("raw_wen_n1", 32'(bus.rf_wen), 32'd1);
    check("raw_waddr_n1", 32'(bus.rf_waddr), 32'd3);
    check("raw_wdata_n1", bus.rf_wdata, 32'hDEADBEEF);
    check("raw_stall_n1", 32'(bus.issue_ready), 32'd0);
    next_cyc();
    check("raw_ready_n2", 32'(bus.issue_ready), 32'd1);
    check("raw_busy_clr", 32'(bus.sb_busy), 32'd0);
    check("raw_wen_off", 32'(bus.rf_wen), 32'd0);
    idle();

    // Single LSU write so the next tie goes to EXU
    bus.lsu_valid = 1'b1;
    bus.lsu_rd    = 5'd9;
    bus.lsu_data  = 32'h99;
    #1;
    check("prime_lsu_gnt", 32'(bus.lsu_ready), 32'd1);
    next_cyc();
    bus.lsu_valid = 1'b0;
    check("prime_waddr", 32'(bus.rf_waddr), 32'd9);

    // Contention: expect E,L,E,L
    bus.exu_valid = 1'b1;
    bus.exu_rd    = 5'd1;
    bus.exu_data  = 32'hA1;
    bus.lsu_valid = 1'b1;
    bus.lsu_rd    = 5'd2;
    bus.lsu_data  = 32'hB2;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_exu_ready", 32'(bus.exu_ready), 32'(exp_e[k]));
      check("rr_lsu_ready", 32'(bus.lsu_ready), 32'(!exp_e[k]));
      next_cyc();
      check("rr_wen", 32'(bus.rf_wen), 32'd1);
      check("rr_waddr", 32'(bus.rf_waddr), 32'(exp_a[k]));
      check("rr_wdata", bus.rf_wdata, exp_d[k]);
    end
    idle();

    // Null destinations: x0 and x20 granted in turn, never written, busy untouched
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd6;
    bus.issue_rd_en = 1'b1;
    next_cyc();
    idle();
    check("null_busy6", 32'(bus.sb_busy), 32'h40);
    bus.exu_valid = 1'b1;
    bus.exu_rd    = 5'd0;
    bus.exu_data  = 32'hFFFFFFFF;
    bus.lsu_valid = 1'b1;
    bus.lsu_rd    = 5'd20;
    bus.lsu_data  = 32'hFFFFFFFF;
    #1;
    check("null_exu_first", 32'(bus.exu_ready), 32'd1);
    check("null_lsu_wait", 32'(bus.lsu_ready), 32'd0);
    next_cyc();
    bus.exu_valid = 1'b0;
    #1;
    check("null_lsu_gnt", 32'(bus.lsu_ready), 32'd1);
    check("null_x0_wen", 32'(bus.rf_wen), 32'd0);
    next_cyc();
    bus.lsu_valid = 1'b0;
    check("null_x20_wen", 32'(bus.rf_wen), 32'd0);
    check("null_busy_keep", 32'(bus.sb_busy), 32'h40);
    bus.issue_valid  = 1'b1;
    bus.issue_rs1    = 5'd0;
    bus.issue_rs1_en = 1'b1;
    bus.issue_rs2    = 5'd20;
    bus.issue_rs2_en = 1'b1;
    bus.issue_rd     = 5'd0;
    bus.issue_rd_en  = 1'b1;
    #1;
    check("null_issue_ready", 32'(bus.issue_ready), 32'd1);
    bus.issue_rs1 = 5'd6;
    #1;
    check("busy6_stall", 32'(bus.issue_ready), 32'd0);
    idle();
    bus.exu_valid = 1'b1;
    bus.exu_rd    = 5'd6;
    bus.exu_data  = 32'h66;
    next_cyc();
    bus.exu_valid = 1'b0;
    check("x6_waddr", 32'(bus.rf_waddr), 32'd6);
    next_cyc();
    check("x6_busy_clr", 32'(bus.sb_busy), 32'd0);

    // WAW on x7
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd7;
    bus.issue_rd_en = 1'b1;
    next_cyc();
    check("waw_busy7", 32'(bus.sb_busy), 32'h80);
    check("waw_stall", 32'(bus.issue_ready), 32'd0);
    bus.lsu_valid = 1'b1;
    bus.lsu_rd    = 5'd7;
    bus.lsu_data  = 32'h77;
    #1;
    check("waw_lsu_gnt", 32'(bus.lsu_ready), 32'd1);
    next_cyc();
    bus.lsu_valid = 1'b0;
    #1;
    check("waw_wen", 32'(bus.rf_wen), 32'd1);
    check("waw_waddr", 32'(bus.rf_waddr), 32'd7);
    check("waw_stall_wb", 32'(bus.issue_ready), 32'd0);
    next_cyc();
    check("waw_ready", 32'(bus.issue_ready), 32'd1);
    check("waw_busy_clr", 32'(bus.sb_busy), 32'd0);
    next_cyc();
    bus.issue_valid = 1'b0;
    check("waw_reissue_busy", 32'(bus.sb_busy), 32'h80);

    // Asynchronous reset with busy[4] and rf_wen both set
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd4;
    bus.issue_rd_en = 1'b1;
    bus.exu_valid   = 1'b1;
    bus.exu_rd      = 5'd7;
    bus.exu_data    = 32'h1234;
    next_cyc();
    idle();
    #1;
    check("arst_pre_wen", 32'(bus.rf_wen), 32'd1);
    check("arst_pre_busy", 32'(bus.sb_busy), 32'h90);
    rst = 1'b0;
    #1;
    check("arst_busy", 32'(bus.sb_busy), 32'd0);
    check("arst_wen", 32'(bus.rf_wen), 32'd0);
    check("arst_waddr", 32'(bus.rf_waddr), 32'd0);
    next_cyc();
    rst = 1'b1;
    #1;
    check("arst_release_ready", 32'(bus.issue_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
